// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU subsystem: bus-owner encoding, the port
// indices used by the arbiter and memory map, and a counter-width helper.
package cpu_pkg;

    localparam logic ARB_OWN_C = 1'b0;
    localparam logic ARB_OWN_D = 1'b1;

    // Index of each requester in per-port vectors (grant, read issue).
    localparam int PORT_C = 0;
    localparam int PORT_D = 1;

    typedef enum logic {
        OWN_C = ARB_OWN_C,
        OWN_D = ARB_OWN_D
    } arb_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rd_return.sv
// One-deep read-return stage: remembers which port issued a read last cycle
// and steers the RAM read data to that port only.
module mem_bus_arbiter_rd_return
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rd_issue,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata
);

    logic [1:0] rvalid_q;

    // Register the per-port read issue; reset drops any return in flight.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q <= '0;
        end else begin
            rvalid_q <= rd_issue;
        end
    end

    assign c_rvalid = rvalid_q[PORT_C];
    assign d_rvalid = rvalid_q[PORT_D];
    assign c_rdata  = rvalid_q[PORT_C] ? mem_rdata : '0;
    assign d_rdata  = rvalid_q[PORT_D] ? mem_rdata : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single synchronous system RAM port. The CPU owns
// the bus by default; a DMA that keeps losing is handed ownership for a short
// burst, unless the CPU holds c_lock for a multi-cycle sequence.
module mem_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int MAX_CPU_RUN = 4,
    parameter int DMA_BURST   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STARVE_W = cnt_width(MAX_CPU_RUN);
    localparam int BURST_W  = cnt_width(DMA_BURST);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(MAX_CPU_RUN - 1);
    localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(DMA_BURST - 1);

    arb_state_t          state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic [1:0]          gnt;
    logic [1:0]          rd_issue;

    // Pick this cycle's winner: the owner if it asks, otherwise the other port.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave a value held (no inferred latch).
    always_comb begin
        gnt = '0;
        if (state == OWN_D) begin
            if (d_req)      gnt[PORT_D] = 1'b1;
            else if (c_req) gnt[PORT_C] = 1'b1;
        end else begin
            if (c_req)      gnt[PORT_C] = 1'b1;
            else if (d_req) gnt[PORT_D] = 1'b1;
        end
    end

    assign c_gnt  = gnt[PORT_C];
    assign d_gnt  = gnt[PORT_D];
    assign mem_en = |gnt;

    // Route the winner's access onto the RAM port; idle bus drives zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PORT_C]) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else if (gnt[PORT_D]) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Flag which port issued a read, for the one-cycle-later return.
    always_comb begin
        rd_issue         = '0;
        rd_issue[PORT_C] = gnt[PORT_C] & ~c_we;
        rd_issue[PORT_D] = gnt[PORT_D] & ~d_we;
    end

    // Ownership FSM: count CPU wins over a waiting DMA, hand over after
    // MAX_CPU_RUN of them, and take the bus back after a DMA burst or as soon
    // as the DMA stops asking. The decision above always uses the pre-edge
    // state, so a hand-over never cancels the grant already given this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= OWN_C;
            starve_cnt <= '0;
            burst_cnt  <= '0;
        end else begin
            case (state)
                OWN_C: begin
                    if (c_req && d_req) begin
                        if (!c_lock) begin
                            if (starve_cnt == STARVE_LAST) begin
                                state      <= OWN_D;
                                starve_cnt <= '0;
                                burst_cnt  <= '0;
                            end else begin
                                starve_cnt <= starve_cnt + STARVE_W'(1);
                            end
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                OWN_D: begin
                    if (gnt[PORT_D]) begin
                        if (burst_cnt == BURST_LAST) begin
                            state     <= OWN_C;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        state     <= OWN_C;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state      <= OWN_C;
                    starve_cnt <= '0;
                    burst_cnt  <= '0;
                end
            endcase
        end
    end

    mem_bus_arbiter_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk       (clk),
        .reset     (reset),
        .rd_issue  (rd_issue),
        .mem_rdata (mem_rdata),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a RAM model on the memory port, a transaction-
// level reference model of ownership and read return, directed scenarios with
// literal expectations, then randomized traffic phases.
module tb_mem_bus_arbiter;

    localparam int ADDR_W      = 16;
    localparam int DATA_W      = 8;
    localparam int MAX_CPU_RUN = 4;
    localparam int DMA_BURST   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              c_req, c_we, c_lock;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt, c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              d_req, d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt, d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .MAX_CPU_RUN (MAX_CPU_RUN),
        .DMA_BURST   (DMA_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_lock    (c_lock),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-up RAM contents; 0x1234 holds 0xA9 for the first directed read.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA9;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM on the arbiter's memory port.
    logic [7:0] ram    [0:65535];
    bit         ram_wr [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            end
        end
    end

    // Reference model state: who owns the bus, how many times the waiting DMA
    // has been passed over, how many DMA grants this ownership period, the
    // expected memory image and the read return due next cycle.
    bit         own_d;
    int         denied;
    int         taken;
    bit         exp_c_rv, exp_d_rv;
    logic [7:0] exp_c_rd, exp_d_rd;
    logic [7:0] exp_mem [0:65535];
    bit         exp_wr  [0:65535];

    function automatic logic [7:0] model_read(input logic [15:0] a);
        return exp_wr[a] ? exp_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        own_d    = 1'b0;
        denied   = 0;
        taken    = 0;
        exp_c_rv = 1'b0;
        exp_d_rv = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%s expected=%s at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string who();
        if (c_gnt) return "C";
        if (d_gnt) return "D";
        return "-";
    endfunction

    // One bus cycle: drive both requesters after the falling edge, compare
    // every output against the model, then advance the model to the next edge.
    task automatic cycle(input bit cr, input bit cw, input bit cl,
                         input logic [15:0] ca, input logic [7:0] cd,
                         input bit dr, input bit dw,
                         input logic [15:0] da, input logic [7:0] dd,
                         output bit gc, output bit gd);
        logic        ex_we;
        logic [15:0] ex_addr;
        logic [7:0]  ex_wd;
        @(negedge clk);
        c_req = cr; c_we = cw; c_lock = cl; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        // Owner wins a contested cycle; an uncontested requester always wins.
        gc      = cr && (!dr || !own_d);
        gd      = dr && (!cr || own_d);
        ex_we   = gc ? cw : (gd ? dw : 1'b0);
        ex_addr = gc ? ca : (gd ? da : 16'h0);
        ex_wd   = gc ? cd : (gd ? dd : 8'h0);
        check("c_gnt",     32'(c_gnt),     32'(gc));
        check("d_gnt",     32'(d_gnt),     32'(gd));
        check("mem_en",    32'(mem_en),    32'(gc | gd));
        check("mem_we",    32'(mem_we),    32'(ex_we));
        check("mem_addr",  32'(mem_addr),  32'(ex_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(ex_wd));
        check("c_rvalid",  32'(c_rvalid),  32'(exp_c_rv));
        check("c_rdata",   32'(c_rdata),   exp_c_rv ? 32'(exp_c_rd) : 32'h0);
        check("d_rvalid",  32'(d_rvalid),  32'(exp_d_rv));
        check("d_rdata",   32'(d_rdata),   exp_d_rv ? 32'(exp_d_rd) : 32'h0);
        // Read data comes back next cycle; writes update the image now.
        exp_c_rv = gc && !cw;
        exp_d_rv = gd && !dw;
        if (exp_c_rv) exp_c_rd = model_read(ca);
        if (exp_d_rv) exp_d_rd = model_read(da);
        if (gc && cw) begin exp_mem[ca] = cd; exp_wr[ca] = 1'b1; end
        if (gd && dw) begin exp_mem[da] = dd; exp_wr[da] = 1'b1; end
        // Ownership rules.
        if (!own_d) begin
            if (cr && dr) begin
                if (!cl) begin
                    denied++;
                    if (denied == MAX_CPU_RUN) begin
                        own_d  = 1'b1;
                        denied = 0;
                        taken  = 0;
                    end
                end
            end else begin
                denied = 0;
            end
        end else begin
            if (dr) begin
                taken++;
                if (taken == DMA_BURST) begin
                    own_d = 1'b0;
                    taken = 0;
                end
            end else begin
                own_d = 1'b0;
                taken = 0;
            end
        end
    endtask

    task automatic idle();
        bit gc, gd;
        cycle(0, 0, 0, 16'h0, 8'h0, 0, 0, 16'h0, 8'h0, gc, gd);
    endtask

    // Both ports requesting fixed reads; returns who the DUT granted.
    task automatic both_reads(input bit cl, output string ch);
        bit gc, gd;
        cycle(1, 0, cl, 16'h0010, 8'h0, 1, 0, 16'h0020, 8'h0, gc, gd);
        ch = who();
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 15));
    endfunction

    initial begin
        bit    gc, gd;
        string ch, seq;
        int    c_cnt, d_cnt;
        bit    cp, cwv, clv, dp, dwv;
        logic [15:0] cav, dav;
        logic [7:0]  cdv, ddv;
        int    cprob [8] = '{90, 50, 20, 100, 70, 100, 30, 60};
        int    dprob [8] = '{90, 50, 80, 100, 70, 100, 90, 40};
        int    lmode [8] = '{0, 0, 0, 0, 1, 1, 1, 0};

        c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_c_gnt",    32'(c_gnt),    0);
        check("rst_d_gnt",    32'(d_gnt),    0);
        check("rst_mem_en",   32'(mem_en),   0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_c_rvalid", 32'(c_rvalid), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        reset = 1'b0;

        // Single CPU read of 0x1234.
        cycle(1, 0, 0, 16'h1234, 8'h0, 0, 0, 16'h0, 8'h0, gc, gd);
        check("t1_c_gnt",    32'(c_gnt),    1);
        check("t1_mem_addr", 32'(mem_addr), 32'h1234);
        check("t1_mem_we",   32'(mem_we),   0);
        idle();
        check("t1_c_rvalid", 32'(c_rvalid), 1);
        check("t1_c_rdata",  32'(c_rdata),  32'hA9);
        check("t1_d_rvalid", 32'(d_rvalid), 0);

        // Continuous contention without lock.
        seq = "";
        repeat (12) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t2_grant_seq", seq, "CCCCDDCCCCDD");

        // Three denials, then lock for 20 cycles, then release.
        seq = "";
        repeat (3) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t3_pre_seq", seq, "CCC");
        c_cnt = 0; d_cnt = 0;
        repeat (20) begin
            both_reads(1, ch);
            if (ch == "C") c_cnt++;
            if (ch == "D") d_cnt++;
        end
        check("t3_lock_c_cnt", 32'(c_cnt), 20);
        check("t3_lock_d_cnt", 32'(d_cnt), 0);
        both_reads(0, ch);
        check_str("t3_release", ch, "C");
        seq = "";
        repeat (3) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t3_after_release", seq, "DDC");
        idle();

        // DMA write then read-back while the CPU is idle.
        cycle(0, 0, 0, 16'h0, 8'h0, 1, 1, 16'h0200, 8'h55, gc, gd);
        check("t4_wr_d_gnt",  32'(d_gnt),     1);
        check("t4_wr_mem_we", 32'(mem_we),    1);
        check("t4_wr_wdata",  32'(mem_wdata), 32'h55);
        cycle(0, 0, 0, 16'h0, 8'h0, 1, 0, 16'h0200, 8'h0, gc, gd);
        check("t4_rd_d_gnt",  32'(d_gnt),    1);
        check("t4_rd_mem_we", 32'(mem_we),   0);
        check("t4_rd_addr",   32'(mem_addr), 32'h0200);
        idle();
        check("t4_d_rvalid", 32'(d_rvalid), 1);
        check("t4_d_rdata",  32'(d_rdata),  32'h55);
        check("t4_c_rvalid", 32'(c_rvalid), 0);
        both_reads(0, ch);
        check_str("t4_still_own_c", ch, "C");
        idle();

        // DMA drops its request after one burst grant.
        seq = "";
        repeat (5) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t5_into_own_d", seq, "CCCCD");
        cycle(1, 0, 0, 16'h0010, 8'h0, 0, 0, 16'h0, 8'h0, gc, gd);
        check_str("t5_c_served", who(), "C");
        seq = "";
        repeat (5) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t5_back_own_c", seq, "CCCCD");
        idle();
        idle();

        // Reset the cycle after a granted CPU read.
        cycle(1, 0, 0, 16'h0030, 8'h0, 0, 0, 16'h0, 8'h0, gc, gd);
        check("t6_c_gnt", 32'(c_gnt), 1);
        @(negedge clk);
        reset = 1'b1;
        c_req = 0; d_req = 0; c_lock = 0;
        #1;
        check("t6_rvalid_in_rst", 32'(c_rvalid), 0);
        check("t6_rdata_in_rst",  32'(c_rdata),  0);
        @(posedge clk);
        #1;
        check("t6_rvalid_rst_edge", 32'(c_rvalid), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seq = "";
        repeat (5) begin both_reads(0, ch); seq = {seq, ch}; end
        check_str("t6_after_rst_seq", seq, "CCCCD");
        idle();
        idle();

        // Randomized traffic phases; requesters hold a transaction until granted.
        cp = 0; dp = 0; clv = 0; cwv = 0; dwv = 0;
        cav = '0; dav = '0; cdv = '0; ddv = '0;
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 250; k++) begin
                if (!cp && $urandom_range(0, 99) < cprob[p]) begin
                    cp = 1; cwv = ($urandom_range(0, 2) == 0);
                    cav = rand_addr(); cdv = 8'($urandom);
                end
                if (!dp && $urandom_range(0, 99) < dprob[p]) begin
                    dp = 1; dwv = ($urandom_range(0, 2) == 0);
                    dav = rand_addr(); ddv = 8'($urandom);
                end
                if (lmode[p] == 0) clv = 0;
                else if ($urandom_range(0, 7) == 0) clv = ~clv;
                cycle(cp, cwv, clv, cav, cdv, dp, dwv, dav, ddv, gc, gd);
                if (gc) cp = 0;
                if (gd) dp = 0;
            end
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single synchronous system RAM port between two requesters: the CPU core (port C) and a DMA/debug loader (port D).
- Per-cycle arbitration with CPU default ownership, a starvation guard for D, bounded D bursts, and a CPU lock for multi-cycle sequences.
- Sits between cpu_core's address/data path and the RAM. Read data returns one cycle after grant.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 8, data width.
- MAX_CPU_RUN, 4, consecutive cycles D may be denied while C wins before D is forced ownership (>=1).
- DMA_BURST, 2, maximum consecutive D grants per forced ownership period (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- c_req  in  1  CPU access request.
- c_we  in  1  CPU write enable (0 = read).
- c_lock  in  1  CPU holds the bus; suppresses starvation hand-over.
- c_addr  in  ADDR_W  CPU address.
- c_wdata  in  DATA_W  CPU write data.
- c_gnt  out  1  combinational; CPU access accepted this cycle.
- c_rvalid  out  1  registered; CPU read data valid this cycle.
- c_rdata  out  DATA_W  CPU read data.
- d_req, d_we, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  DMA request (same meaning as the CPU inputs).
- d_gnt, d_rvalid, d_rdata  out  1/1/DATA_W  DMA grant and read return (same meaning as the CPU outputs).
- mem_en  out  1  RAM access this cycle.
- mem_we  out  1  RAM write.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- FSM states: OWN_C, OWN_D. Counters: starve_cnt (0..MAX_CPU_RUN-1) and burst_cnt (0..DMA_BURST-1), each $clog2 wide with a minimum of 1 bit.
- Reset value:
  - state is OWN_C, both counters are 0.
  - c_rvalid and d_rvalid are 0.
  - gnt outputs and mem_* outputs are 0 because no request is present.
- Reset mid-operation discards any pending rvalid.
- Winner in OWN_C: C if c_req, else D if d_req, else none.
- Winner in OWN_D: D if d_req, else C if c_req, else none.
- gnt: combinational, equal to the winner; at most one gnt is high per cycle.
- mem_* mux the winner's signals. mem_en = |gnt. mem_we = winner's we & mem_en. With no winner, mem_addr and mem_wdata are 0.
- OWN_C transitions:
  - c_req & d_req & !c_lock: if starve_cnt == MAX_CPU_RUN-1, go to OWN_D with starve_cnt<=0 and burst_cnt<=0; else starve_cnt++.
  - c_req & d_req & c_lock: starve_cnt holds; stay in OWN_C.
  - Otherwise (D idle, or D granted because C is idle): starve_cnt<=0.
- OWN_D transitions:
  - d_gnt & burst_cnt == DMA_BURST-1: go to OWN_C, burst_cnt<=0.
  - d_gnt otherwise: burst_cnt++.
  - !d_req: go to OWN_C immediately (this cycle's C grant is still served); burst_cnt<=0.
  - c_lock is ignored in OWN_D.
- Read return:
  - x_rvalid is registered: set the cycle after x_gnt & !x_we.
  - x_rdata = mem_rdata when x_rvalid, else 0.
  - A write never produces rvalid.
  - Back-to-back reads by alternating owners each receive their own rvalid; pipeline depth is 1.
- Simultaneous events:
  - The grant decision uses the current state; the transition applies at the clock edge.
  - A hand-over never drops the request that won this cycle.
- Requesters hold req/addr/we/wdata until they see gnt.

Decomposition:
- Shared package (cpu_pkg): ARB_OWN_C=1'b0, ARB_OWN_D=1'b1, plus a port-index localparam pair (PORT_C=0, PORT_D=1) reused by the memory map/top level.
- No sub-module required.
- Optional: arb_rd_return, holding the 1-deep rvalid/owner register and the rdata steering, instantiated once.

Test Plan (MAX_CPU_RUN=4, DMA_BURST=2):
- Reset, then single C read at 0x1234 with mem_rdata=0xA9 → c_gnt=1 same cycle, mem_addr=0x1234, mem_we=0; next cycle c_rvalid=1, c_rdata=0xA9, d_rvalid=0.
- c_req and d_req held high continuously, no lock → grant sequence C,C,C,C,D,D,C,C,C,C,D,D,…; starve_cnt is 3 on the 4th C cycle.
- Same as the previous scenario but c_lock=1 throughout → C granted every cycle for 20 cycles, d_gnt never 1; deassert c_lock → D granted within 1 cycle (starve_cnt was held at 3).
- C idle, D writes 0x55 to 0x0200 then reads 0x0200 returning 0x55 → d_gnt both cycles, mem_we=1 then 0; d_rvalid=1 with 0x55 one cycle after the read; state remains OWN_C.
- In OWN_D after 1 D grant, d_req drops while c_req=1 → C granted that cycle, next state OWN_C, burst_cnt=0.
- Assert reset the cycle after a granted C read → c_rvalid=0 during and after reset, state OWN_C, counters 0.
